// File: rtl/ipd_stage_pkg.sv
// Shared widths, opcode constants and pre-decode helper for the IPD (inst pre-decode) stage.
package ipd_stage_pkg;

  localparam int IF_TO_IPD_BUS_WD = 96;
  localparam int IPD_TO_ID_BUS_WD = 100;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [5:0] OP_BLT  = 6'h18;
  localparam logic [5:0] OP_BGE  = 6'h19;
  localparam logic [5:0] OP_BLTU = 6'h1a;
  localparam logic [5:0] OP_BGEU = 6'h1b;

  localparam int FLAG_JIRL    = 3;
  localparam int FLAG_B_BL    = 2;
  localparam int FLAG_COND_BR = 1;
  localparam int FLAG_LINK    = 0;

  // jirl only writes a link register when rd is not r0
  function automatic logic [3:0] predecode(input logic [5:0] opcode, input logic [4:0] rd);
    logic [3:0] flags;
    flags = '0;
    flags[FLAG_JIRL]    = (opcode == OP_JIRL);
    flags[FLAG_B_BL]    = (opcode == OP_B) || (opcode == OP_BL);
    flags[FLAG_COND_BR] = (opcode >= OP_BEQ) && (opcode <= OP_BGEU);
    flags[FLAG_LINK]    = (opcode == OP_BL) || ((opcode == OP_JIRL) && (rd != 5'd0));
    return flags;
  endfunction

endpackage

// File: rtl/ipd_stage_inst_skid_buf.sv
// One-entry skid buffer holding instruction RAM data that arrived while the stage was stalled.
module ipd_stage_inst_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] rdata,
  output logic [31:0] inst,
  output logic        buf_valid
);

  logic [31:0] buf_data;

  // NOTE: the buffer is a single register, so it is reset along with its flag; nothing forbids it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (capture && !buf_valid) begin
      buf_valid <= 1'b1;
      buf_data  <= rdata;
    end
  end

  // RAM data is only valid in the first presented cycle; afterwards the buffered copy wins
  assign inst = buf_valid ? buf_data : rdata;

endmodule

// File: rtl/ipd_stage.sv
// IPD pipeline stage: accepts the IF bundle, merges RAM data, pre-decodes and registers it for ID.
module ipd_stage
  import ipd_stage_pkg::*;
#(
  parameter int          IF_BUS_WD = IF_TO_IPD_BUS_WD,
  parameter int          ID_BUS_WD = IPD_TO_ID_BUS_WD,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IF_BUS_WD-1:0] IF_to_IPD_bus,
  input  logic                 IF_to_IPD_valid,
  output logic                 IPD_allow_in,
  input  logic [31:0]          inst_ram_rdata,
  input  logic                 br_taken_cancel,
  input  logic                 ID_allow_in,
  output logic                 IPD_to_ID_valid,
  output logic [ID_BUS_WD-1:0] IPD_to_ID_bus
);

  logic        ipd_valid;
  logic        transfer;
  logic        stall_capture;
  logic [31:0] inst;
  logic [3:0]  flags;
  logic        unused_placeholder;

  assign IPD_allow_in    = ~ipd_valid | ID_allow_in;
  assign IPD_to_ID_valid = ipd_valid & ~br_taken_cancel;
  assign transfer        = IF_to_IPD_valid & IPD_allow_in & ~br_taken_cancel;
  assign stall_capture   = IF_to_IPD_valid & ~IPD_allow_in;

  ipd_stage_inst_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .capture   (stall_capture),
    .clear     (transfer | br_taken_cancel),
    .rdata     (inst_ram_rdata),
    .inst      (inst),
    .buf_valid ()
  );

  assign flags = predecode(inst[31:26], inst[4:0]);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ipd_valid <= 1'b0;
    end else if (br_taken_cancel) begin
      ipd_valid <= 1'b0;
    end else if (IPD_allow_in) begin
      ipd_valid <= IF_to_IPD_valid;
    end
  end

  // Data holds across cancel; only the valid bit is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IPD_to_ID_bus <= {4'b0000, RESET_PC + 32'd4, RESET_PC, 32'h0};
    end else if (transfer) begin
      IPD_to_ID_bus <= {flags, IF_to_IPD_bus[95:64], IF_to_IPD_bus[63:32], inst};
    end
  end

  assign unused_placeholder = &{1'b0, IF_to_IPD_bus[31:0]};

endmodule

// File: tb/tb_ipd_stage.sv
// Directed bench for ipd_stage: handshake, skid buffer, pre-decode flags, cancel and async reset.
module tb_ipd_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] IF_to_IPD_bus;
  logic        IF_to_IPD_valid;
  logic        IPD_allow_in;
  logic [31:0] inst_ram_rdata;
  logic        br_taken_cancel;
  logic        ID_allow_in;
  logic        IPD_to_ID_valid;
  logic [99:0] IPD_to_ID_bus;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ipd_stage dut (
    .clk             (clk),
    .reset           (reset),
    .IF_to_IPD_bus   (IF_to_IPD_bus),
    .IF_to_IPD_valid (IF_to_IPD_valid),
    .IPD_allow_in    (IPD_allow_in),
    .inst_ram_rdata  (inst_ram_rdata),
    .br_taken_cancel (br_taken_cancel),
    .ID_allow_in     (ID_allow_in),
    .IPD_to_ID_valid (IPD_to_ID_valid),
    .IPD_to_ID_bus   (IPD_to_ID_bus)
  );

  function automatic logic [99:0] exp_bus(input logic [3:0] f, input logic [31:0] pc,
                                          input logic [31:0] inst);
    return {f, pc + 32'd4, pc, inst};
  endfunction

  task automatic present(input logic [31:0] pc, input logic [31:0] rdata);
    IF_to_IPD_bus   = {pc + 32'd4, pc, 32'h0};
    inst_ram_rdata  = rdata;
    IF_to_IPD_valid = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (IPD_to_ID_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", IPD_to_ID_valid);
    end
    n_cmp++;
    if (IPD_allow_in !== 1'b1) begin
      n_bad++; $display("FAIL reset_allow_in: got %b want 1", IPD_allow_in);
    end
    n_cmp++;
    if (IPD_to_ID_bus !== exp_bus(4'b0000, 32'h1c000000, 32'h0)) begin
      n_bad++; $display("FAIL reset_bus: got %h want %h", IPD_to_ID_bus, exp_bus(4'b0000, 32'h1c000000, 32'h0));
    end
  endtask

  task automatic test_basic();
    ID_allow_in = 1'b1;
    present(32'h1c000000, 32'h02800000);
    #1;
    n_cmp++;
    if (IPD_allow_in !== 1'b1) begin
      n_bad++; $display("FAIL basic_allow_in: got %b want 1", IPD_allow_in);
    end
    next_cycle();
    n_cmp++;
    if (IPD_to_ID_valid !== 1'b1) begin
      n_bad++; $display("FAIL basic_valid: got %b want 1", IPD_to_ID_valid);
    end
    n_cmp++;
    if (IPD_to_ID_bus !== exp_bus(4'b0000, 32'h1c000000, 32'h02800000)) begin
      n_bad++; $display("FAIL basic_bus: got %h want %h", IPD_to_ID_bus, exp_bus(4'b0000, 32'h1c000000, 32'h02800000));
    end
    IF_to_IPD_valid = 1'b0;
    next_cycle();
    n_cmp++;
    if (IPD_to_ID_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_bubble_valid: got %b want 0", IPD_to_ID_valid);
    end
  endtask

  task automatic test_stall();
    present(32'h1c000010, 32'h02800000);
    next_cycle();
    ID_allow_in = 1'b0;
    present(32'h1c000004, 32'h50000800);
    #1;
    n_cmp++;
    if (IPD_allow_in !== 1'b0) begin
      n_bad++; $display("FAIL stall_allow_in_first: got %b want 0", IPD_allow_in);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      inst_ram_rdata = 32'hdeadbeef;
      n_cmp++;
      if (IPD_allow_in !== 1'b0) begin
        n_bad++; $display("FAIL stall_allow_in[%0d]: got %b want 0", i, IPD_allow_in);
      end
      n_cmp++;
      if (IPD_to_ID_bus[63:32] !== 32'h1c000010) begin
        n_bad++; $display("FAIL stall_hold_pc[%0d]: got %h want 1c000010", i, IPD_to_ID_bus[63:32]);
      end
    end
    ID_allow_in = 1'b1;
    #1;
    n_cmp++;
    if (IPD_allow_in !== 1'b1) begin
      n_bad++; $display("FAIL stall_release_allow_in: got %b want 1", IPD_allow_in);
    end
    next_cycle();
    n_cmp++;
    if (IPD_to_ID_bus !== exp_bus(4'b0100, 32'h1c000004, 32'h50000800)) begin
      n_bad++; $display("FAIL stall_release_bus: got %h want %h", IPD_to_ID_bus, exp_bus(4'b0100, 32'h1c000004, 32'h50000800));
    end
    n_cmp++;
    if (IPD_to_ID_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_release_valid: got %b want 1", IPD_to_ID_valid);
    end
    IF_to_IPD_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs   [4] = '{32'h1c000020, 32'h1c000024, 32'h1c000028, 32'h1c00002c};
    logic [31:0] insts [4] = '{32'h54000400, 32'h58000000, 32'h4c000001, 32'h4c000000};
    logic [3:0]  flgs  [4] = '{4'b0101, 4'b0010, 4'b1001, 4'b1000};
    ID_allow_in = 1'b1;
    present(pcs[0], insts[0]);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      n_cmp++;
      if (IPD_to_ID_bus !== exp_bus(flgs[i], pcs[i], insts[i])) begin
        n_bad++; $display("FAIL b2b_bus[%0d]: got %h want %h", i, IPD_to_ID_bus, exp_bus(flgs[i], pcs[i], insts[i]));
      end
      n_cmp++;
      if (IPD_to_ID_valid !== 1'b1) begin
        n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, IPD_to_ID_valid);
      end
      if (i < 3) present(pcs[i+1], insts[i+1]);
    end
    IF_to_IPD_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_cancel();
    ID_allow_in = 1'b1;
    present(32'h1c000030, 32'h02800000);
    next_cycle();
    present(32'h1c000034, 32'h50000800);
    br_taken_cancel = 1'b1;
    #1;
    n_cmp++;
    if (IPD_to_ID_valid !== 1'b0) begin
      n_bad++; $display("FAIL cancel_masked_valid: got %b want 0", IPD_to_ID_valid);
    end
    next_cycle();
    br_taken_cancel = 1'b0;
    IF_to_IPD_valid = 1'b0;
    n_cmp++;
    if (IPD_to_ID_valid !== 1'b0) begin
      n_bad++; $display("FAIL cancel_next_valid: got %b want 0", IPD_to_ID_valid);
    end
    n_cmp++;
    if (IPD_to_ID_bus[63:32] !== 32'h1c000030) begin
      n_bad++; $display("FAIL cancel_bus_hold: got %h want 1c000030", IPD_to_ID_bus[63:32]);
    end
    n_cmp++;
    if (IPD_allow_in !== 1'b1) begin
      n_bad++; $display("FAIL cancel_allow_in: got %b want 1", IPD_allow_in);
    end
    next_cycle();
  endtask

  task automatic test_cancel_stall();
    ID_allow_in = 1'b1;
    present(32'h1c000040, 32'h02800000);
    next_cycle();
    ID_allow_in = 1'b0;
    present(32'h1c000044, 32'h50000800);
    next_cycle();
    inst_ram_rdata  = 32'hdeadbeef;
    br_taken_cancel = 1'b1;
    next_cycle();
    br_taken_cancel = 1'b0;
    present(32'h1c000048, 32'h54000400);
    #1;
    n_cmp++;
    if (IPD_allow_in !== 1'b1) begin
      n_bad++; $display("FAIL cstall_allow_in: got %b want 1", IPD_allow_in);
    end
    next_cycle();
    n_cmp++;
    if (IPD_to_ID_bus !== exp_bus(4'b0101, 32'h1c000048, 32'h54000400)) begin
      n_bad++; $display("FAIL cstall_live_bus: got %h want %h", IPD_to_ID_bus, exp_bus(4'b0101, 32'h1c000048, 32'h54000400));
    end
    n_cmp++;
    if (IPD_to_ID_valid !== 1'b1) begin
      n_bad++; $display("FAIL cstall_valid: got %b want 1", IPD_to_ID_valid);
    end
    ID_allow_in     = 1'b1;
    IF_to_IPD_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_async_reset();
    ID_allow_in = 1'b1;
    present(32'h1c000050, 32'h02800000);
    next_cycle();
    ID_allow_in = 1'b0;
    present(32'h1c000054, 32'h50000800);
    next_cycle();
    inst_ram_rdata = 32'hdeadbeef;
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (IPD_to_ID_valid !== 1'b0) begin
      n_bad++; $display("FAIL areset_valid: got %b want 0", IPD_to_ID_valid);
    end
    n_cmp++;
    if (IPD_allow_in !== 1'b1) begin
      n_bad++; $display("FAIL areset_allow_in: got %b want 1", IPD_allow_in);
    end
    n_cmp++;
    if (IPD_to_ID_bus !== exp_bus(4'b0000, 32'h1c000000, 32'h0)) begin
      n_bad++; $display("FAIL areset_bus: got %h want %h", IPD_to_ID_bus, exp_bus(4'b0000, 32'h1c000000, 32'h0));
    end
    #1;
    reset = 1'b0;
    ID_allow_in = 1'b1;
    present(32'h1c000058, 32'h54000400);
    next_cycle();
    n_cmp++;
    if (IPD_to_ID_bus !== exp_bus(4'b0101, 32'h1c000058, 32'h54000400)) begin
      n_bad++; $display("FAIL areset_after_bus: got %h want %h", IPD_to_ID_bus, exp_bus(4'b0101, 32'h1c000058, 32'h54000400));
    end
    IF_to_IPD_valid = 1'b0;
    next_cycle();
  endtask

  initial begin
    reset           = 1'b0;
    IF_to_IPD_bus   = '0;
    IF_to_IPD_valid = 1'b0;
    inst_ram_rdata  = '0;
    br_taken_cancel = 1'b0;
    ID_allow_in     = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_basic();
    test_stall();
    test_back_to_back();
    test_cancel();
    test_cancel_stall();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
